// File: rtl/flush_word_unpacker_if.sv
// Word-in / nibble-out handshake bundle
// for the flush word unpacker.
interface flush_word_unpacker_if;
  logic        word_valid_i;
  logic [31:0] word_data_i;
  logic        word_ready_o;
  logic        nib_valid_o;
  logic [3:0]  nib_data_o;
  logic        nib_last_o;
  logic        nib_ready_i;

  modport slave (
    input  word_valid_i,
    input  word_data_i,
    input  nib_ready_i,
    output word_ready_o,
    output nib_valid_o,
    output nib_data_o,
    output nib_last_o
  );

  modport master (
    output word_valid_i,
    output word_data_i,
    output nib_ready_i,
    input  word_ready_o,
    input  nib_valid_o,
    input  nib_data_o,
    input  nib_last_o
  );
endinterface

// File: rtl/flush_word_unpacker.sv
// Buffers padded flush words and replays
// their valid nibbles on a 4-bit stream.
module flush_word_unpacker #(
  parameter int         WORD_DEPTH = 4,
  parameter logic [3:0] PAD_NIBBLE = 4'hC
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  flush_word_unpacker_if.slave bus,
  output logic [$clog2(WORD_DEPTH):0] word_cnt_o,
  output logic [7:0] drop_cnt_o
);
  localparam int PW = $clog2(WORD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [WORD_DEPTH];
  logic [3:0]    len_q [WORD_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    drop_q;
  logic [3:0]    in_len;
  logic [31:0]   head_word;
  logic [3:0]    head_len;
  logic          accept, push, drop;
  logic          hs, last, pop;

  // Scan high to low so the lowest pad wins.
  always_comb begin
    in_len = 4'd8;
    for (int k = 7; k >= 0; k--)
      if (bus.word_data_i[4*k +: 4] == PAD_NIBBLE)
        in_len = 4'(k);
  end

  assign bus.word_ready_o = !clear_i &&
    (cnt_q != CW'(WORD_DEPTH));
  assign accept = bus.word_valid_i &&
    bus.word_ready_o;
  assign push = accept && (in_len != 4'd0);
  assign drop = accept && (in_len == 4'd0);

  assign head_word = mem_q[rd_ptr_q];
  assign head_len  = len_q[rd_ptr_q];
  assign last = ({1'b0, idx_q} == head_len - 4'd1);
  assign hs   = (state_q == SHIFT) && bus.nib_ready_i;
  assign pop  = hs && last;

  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  assign bus.nib_valid_o = (state_q == SHIFT);
  assign bus.nib_data_o  = bus.nib_valid_o ?
    head_word[{idx_q, 2'b00} +: 4] : 4'd0;
  assign bus.nib_last_o  = bus.nib_valid_o && last;

  assign word_cnt_o = cnt_q;
  assign drop_cnt_o = drop_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          state_d = SHIFT;
          idx_d   = 3'd0;
        end
      end
      SHIFT: begin
        if (hs && last) begin
          idx_d   = 3'd0;
          state_d = (cnt_d != '0) ? SHIFT : IDLE;
        end else if (hs) begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Survives clear; only reset zeroes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      drop_q <= '0;
    else if (drop && drop_q != 8'hFF)
      drop_q <= drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.word_data_i;
      len_q[wr_ptr_q] <= in_len;
    end
  end
endmodule

// File: tb/tb_flush_word_unpacker.sv
// Table plus scoreboard bench for
// flush_word_unpacker.
module tb_flush_word_unpacker;
  logic       clk = 0;
  logic       reset;
  logic       clear_i;
  logic [2:0] word_cnt;
  logic [7:0] drop_cnt;

  flush_word_unpacker_if bus ();

  flush_word_unpacker #(
    .WORD_DEPTH(4),
    .PAD_NIBBLE(4'hC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear_i(clear_i),
    .bus(bus),
    .word_cnt_o(word_cnt),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       l;
  } nib_t;

  typedef struct {
    logic [31:0] w;
    int          len;
  } vec_t;

  nib_t sb[$];
  nib_t mon_e;
  nib_t stall_e;
  int   errors = 0;
  int   checks = 0;
  int   exp_drop = 0;

  task automatic check(input string n,
                       input logic [31:0] a,
                       input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.nib_valid_o && bus.nib_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL nib_extra: got %0h expected none",
                 bus.nib_data_o);
      end else begin
        mon_e = sb.pop_front();
        check("nib_data", 32'(bus.nib_data_o), 32'(mon_e.d));
        check("nib_last", 32'(bus.nib_last_o), 32'(mon_e.l));
      end
    end
  end

  task automatic expect_word(input logic [31:0] w,
                             input int len);
    nib_t n;
    for (int k = 0; k < len; k++) begin
      n.d = w[4*k +: 4];
      n.l = (k == len - 1);
      sb.push_back(n);
    end
  endtask

  task automatic send(input logic [31:0] w,
                      input int len);
    int t = 0;
    bus.word_valid_i = 1'b1;
    bus.word_data_i  = w;
    #1;
    while (!bus.word_ready_o && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("send_timeout", 32'(t < 200), 32'd1);
    expect_word(w, len);
    if (len == 0 && exp_drop < 255) exp_drop++;
    @(posedge clk); #1;
    bus.word_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    check("idle_valid", 32'(bus.nib_valid_o), 32'd0);
    check("idle_cnt", 32'(word_cnt), 32'd0);
  endtask

  function automatic logic [31:0] rand_word8();
    logic [31:0] w;
    for (int k = 0; k < 8; k++)
      w[4*k +: 4] = 4'($urandom_range(0, 11));
    return w;
  endfunction

  vec_t tbl[8];
  logic [31:0] fw[5];
  int k;

  initial begin
    tbl[0] = '{32'hCCCC_4321, 4};
    tbl[1] = '{32'h1234_C567, 3};
    tbl[2] = '{32'hCCCC_CCCC, 0};
    tbl[3] = '{32'h8765_4321, 8};
    tbl[4] = '{32'hCCCC_CCC9, 1};
    tbl[5] = '{32'hFFFF_FFF0, 8};
    tbl[6] = '{32'hC000_0000, 7};
    tbl[7] = '{32'h5555_55C5, 1};

    reset = 1'b0;
    clear_i = 1'b0;
    bus.word_valid_i = 1'b0;
    bus.word_data_i = '0;
    bus.nib_ready_i = 1'b1;
    #1;
    check("rst_valid", 32'(bus.nib_valid_o), 32'd0);
    check("rst_data", 32'(bus.nib_data_o), 32'd0);
    check("rst_last", 32'(bus.nib_last_o), 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    #20;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(bus.word_ready_o), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].w, tbl[i].len);
      drain();
      check("tbl_drop", 32'(drop_cnt), 32'(exp_drop));
    end

    send(32'h8765_4321, 8);
    send(32'hCCCC_CCC9, 1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("no_bubble", 32'(bus.nib_valid_o), 32'd1);
    end
    drain();

    for (int i = 0; i < 300; i++)
      send(32'hCCCC_CCCC, 0);
    check("drop_sat", 32'(drop_cnt), 32'd255);
    check("drop_model", 32'(exp_drop), 32'd255);
    check("drop_cnt0", 32'(word_cnt), 32'd0);
    check("drop_valid", 32'(bus.nib_valid_o), 32'd0);

    bus.nib_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) fw[i] = rand_word8();
    for (int i = 0; i < 4; i++) send(fw[i], 8);
    check("full_ready", 32'(bus.word_ready_o), 32'd0);
    check("full_cnt", 32'(word_cnt), 32'd4);
    stall_e = sb[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.nib_valid_o), 32'd1);
      check("stall_data", 32'(bus.nib_data_o), 32'(stall_e.d));
      check("stall_last", 32'(bus.nib_last_o), 32'(stall_e.l));
    end
    @(posedge clk); #1;
    bus.word_valid_i = 1'b1;
    bus.word_data_i = fw[4];
    #1;
    check("full_noacc", 32'(bus.word_ready_o), 32'd0);
    bus.nib_ready_i = 1'b1;
    k = 0;
    while (!bus.word_ready_o && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("reassert_lat", 32'(k), 32'd8);
    expect_word(fw[4], 8);
    @(posedge clk); #1;
    bus.word_valid_i = 1'b0;
    drain();

    send(32'h7654_3210, 8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_i = 1'b1;
    bus.word_valid_i = 1'b1;
    bus.word_data_i = 32'hCCCC_0001;
    #1;
    check("clr_ready", 32'(bus.word_ready_o), 32'd0);
    @(posedge clk); #1;
    clear_i = 1'b0;
    bus.word_valid_i = 1'b0;
    sb.delete();
    check("clr_valid", 32'(bus.nib_valid_o), 32'd0);
    check("clr_cnt", 32'(word_cnt), 32'd0);
    check("clr_drop", 32'(drop_cnt), 32'(exp_drop));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr_stay", 32'(bus.nib_valid_o), 32'd0);
    end
    @(posedge clk); #1;

    send(32'h3333_2222, 8);
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(bus.nib_valid_o), 32'd0);
    check("arst_data", 32'(bus.nib_data_o), 32'd0);
    check("arst_last", 32'(bus.nib_last_o), 32'd0);
    check("arst_cnt", 32'(word_cnt), 32'd0);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    sb.delete();
    exp_drop = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("arst_ready", 32'(bus.word_ready_o), 32'd1);
    @(posedge clk); #1;
    send(32'hCCC0_9A8B, 5);
    drain();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
